// File: rtl/mmc1_ctrl_pkg.sv
// Shared constants and FSM encoding for the MMC1 serial loader.
package mmc1_ctrl_pkg;

  // MMC1 internal register targets, selected by CPU A14:A13
  localparam logic [1:0] REG_CTRL = 2'd0;  // $8000
  localparam logic [1:0] REG_CHR0 = 2'd1;  // $A000
  localparam logic [1:0] REG_CHR1 = 2'd2;  // $C000
  localparam logic [1:0] REG_PRG  = 2'd3;  // $E000

  // A shift reset forces PRG mode 3 in the control register
  localparam logic [4:0] MMC1_RESET_OR = 5'h0C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/mmc1_m2_gen.sv
// Free-running CPU phi2 (M2) generator with a cycle-boundary strobe.
// M2 is low for HALF_CLKS clocks, then high for HALF_CLKS clocks.
module mmc1_m2_gen #(
  parameter int unsigned HALF_CLKS = 2
) (
  input  logic clk,
  input  logic rst,
  output logic m2,
  output logic cyc_start
);

  localparam int unsigned PERIOD = 2 * HALF_CLKS;
  localparam int unsigned PW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] ph;
  logic [PW-1:0] ph_nxt;
  logic          wrap;

  // Next phase; wrapping to 0 marks the start of a new CPU cycle
  always_comb begin
    wrap   = (ph == PW'(PERIOD - 1));
    ph_nxt = wrap ? '0 : ph + 1'b1;
  end

  // Phase counter and registered M2 derived from the next phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= '0;
      m2 <= 1'b0;
    end else begin
      ph <= ph_nxt;
      m2 <= (ph_nxt >= PW'(HALF_CLKS));
    end
  end

  // Strobe is high in the CLK whose closing edge is the boundary
  always_comb begin
    cyc_start = wrap;
  end

endmodule

// File: rtl/mmc1_serial_loader.sv
// MMC1 programming sequencer: converts a parallel register write into five
// serial D0 bus writes (LSB first), or a single D7 shift-reset write.
// Optional feature macro: MMC1_SHADOW_EN adds shadow copies of the four
// MMC1 registers as written by completed requests.
module mmc1_serial_loader
  import mmc1_ctrl_pkg::*;
#(
  parameter int unsigned HALF_CLKS = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_reset,
  input  logic [1:0] req_reg,
  input  logic [4:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       M2,
  output logic       CPU_RnW,
  output logic       nROMSEL,
  output logic       CPU_A14,
  output logic       CPU_A13,
  output logic       CPU_D0,
  output logic       CPU_D7
`ifdef MMC1_SHADOW_EN
  ,
  output logic [4:0] shadow_ctrl,
  output logic [4:0] shadow_chr0,
  output logic [4:0] shadow_chr1,
  output logic [4:0] shadow_prg
`endif
);

  if (HALF_CLKS < 1) begin : g_bad_half_clks
    $error("mmc1_serial_loader: HALF_CLKS must be >= 1");
  end
  if (GAP_CYC < 1) begin : g_bad_gap_cyc
    $error("mmc1_serial_loader: GAP_CYC must be >= 1");
  end

  localparam int unsigned GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

  logic          m2_int;
  logic          cyc_start;

  state_t        state, state_nxt;
  logic          pend, pend_nxt;
  logic          rst_req, rst_req_nxt;
  logic [1:0]    reg_q, reg_nxt;
  logic [4:0]    data_q, data_nxt;
  logic [2:0]    k, k_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic          wr, wr_nxt;
  logic          a14_q, a14_nxt;
  logic          a13_q, a13_nxt;
  logic          d0_q, d0_nxt;
  logic          d7_q, d7_nxt;
  logic          done_q, done_nxt;
  logic          start_write;
  logic [2:0]    bit_idx;

  mmc1_m2_gen #(
    .HALF_CLKS(HALF_CLKS)
  ) u_m2_gen (
    .clk      (CLK),
    .rst      (RST),
    .m2       (m2_int),
    .cyc_start(cyc_start)
  );

  // State, request latch and bus registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      pend    <= 1'b0;
      rst_req <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      k       <= '0;
      gcnt    <= '0;
      wr      <= 1'b0;
      a14_q   <= 1'b0;
      a13_q   <= 1'b0;
      d0_q    <= 1'b0;
      d7_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      rst_req <= rst_req_nxt;
      reg_q   <= reg_nxt;
      data_q  <= data_nxt;
      k       <= k_nxt;
      gcnt    <= gcnt_nxt;
      wr      <= wr_nxt;
      a14_q   <= a14_nxt;
      a13_q   <= a13_nxt;
      d0_q    <= d0_nxt;
      d7_q    <= d7_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state logic; all bus fields change only at CPU-cycle boundaries.
  // An accepted request waits in IDLE (pend=1, not ready) until the next
  // boundary so the first write always gets a full CPU cycle.
  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend;
    rst_req_nxt = rst_req;
    reg_nxt     = reg_q;
    data_nxt    = data_q;
    k_nxt       = k;
    gcnt_nxt    = gcnt;
    wr_nxt      = wr;
    a14_nxt     = a14_q;
    a13_nxt     = a13_q;
    d0_nxt      = d0_q;
    d7_nxt      = d7_q;
    done_nxt    = 1'b0;
    start_write = 1'b0;
    bit_idx     = k;

    case (state)
      ST_IDLE: begin
        if (pend) begin
          if (cyc_start) begin
            state_nxt   = ST_WRITE;
            pend_nxt    = 1'b0;
            start_write = 1'b1;
            bit_idx     = 3'd0;
          end
        end else if (req_valid) begin
          pend_nxt    = 1'b1;
          rst_req_nxt = req_reset;
          reg_nxt     = req_reg;
          data_nxt    = req_data;
          k_nxt       = 3'd0;
        end
      end
      ST_WRITE: begin
        if (cyc_start) begin
          state_nxt = ST_GAP;
          gcnt_nxt  = GW'(GAP_CYC);
        end
      end
      ST_GAP: begin
        if (cyc_start) begin
          if (gcnt == GW'(1)) begin
            if (rst_req || (k == 3'd4)) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt   = ST_WRITE;
              k_nxt       = k + 3'd1;
              bit_idx     = k + 3'd1;
              start_write = 1'b1;
            end
          end else begin
            gcnt_nxt = gcnt - GW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (start_write) begin
      wr_nxt = 1'b1;
      if (rst_req) begin
        {a14_nxt, a13_nxt} = REG_CTRL;
        d0_nxt             = 1'b0;
        d7_nxt             = 1'b1;
      end else begin
        {a14_nxt, a13_nxt} = reg_q;
        d0_nxt             = data_q[bit_idx];
        d7_nxt             = 1'b0;
      end
    end else if (cyc_start) begin
      wr_nxt  = 1'b0;
      a14_nxt = 1'b0;
      a13_nxt = 1'b0;
      d0_nxt  = 1'b0;
      d7_nxt  = 1'b0;
    end
  end

  // Port outputs; nROMSEL is the write-cycle flag gated by M2
  always_comb begin
    req_ready = (state == ST_IDLE) && !pend;
    busy      = !req_ready;
    done      = done_q;
    M2        = m2_int;
    CPU_RnW   = !wr;
    nROMSEL   = !(wr && m2_int);
    CPU_A14   = a14_q;
    CPU_A13   = a13_q;
    CPU_D0    = d0_q;
    CPU_D7    = d7_q;
  end

`ifdef MMC1_SHADOW_EN
  // Shadow copies updated when a request completes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_ctrl <= '0;
      shadow_chr0 <= '0;
      shadow_chr1 <= '0;
      shadow_prg  <= '0;
    end else if (done_nxt) begin
      if (rst_req) begin
        shadow_ctrl <= shadow_ctrl | MMC1_RESET_OR;
      end else begin
        case (reg_q)
          REG_CTRL: shadow_ctrl <= data_q;
          REG_CHR0: shadow_chr0 <= data_q;
          REG_CHR1: shadow_chr1 <= data_q;
          REG_PRG:  shadow_prg  <= data_q;
          default:  shadow_ctrl <= shadow_ctrl;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Directed self-checking bench for mmc1_serial_loader.
// Instance dut uses default parameters; dut2 uses HALF_CLKS=1, GAP_CYC=3.
module tb_mmc1_serial_loader;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req_valid  = 1'b0;
  logic       req_valid2 = 1'b0;
  logic       req_reset  = 1'b0;
  logic [1:0] req_reg    = 2'd0;
  logic [4:0] req_data   = 5'd0;

  logic ready1, busy1, done1, m2_1, rnw1, nrom1, a14_1, a13_1, d0_1, d7_1;
  logic ready2, busy2, done2, m2_2, rnw2, nrom2, a14_2, a13_2, d0_2, d7_2;
`ifdef MMC1_SHADOW_EN
  logic [4:0] sh_ctrl, sh_chr0, sh_chr1, sh_prg;
  logic [4:0] sh2_ctrl, sh2_chr0, sh2_chr1, sh2_prg;
`endif

  // {M2, RnW, nROMSEL, A14, A13, D0, D7, done, ready, busy}
  logic [9:0] bus1, bus2;
  assign bus1 = {m2_1, rnw1, nrom1, a14_1, a13_1, d0_1, d7_1, done1, ready1, busy1};
  assign bus2 = {m2_2, rnw2, nrom2, a14_2, a13_2, d0_2, d7_2, done2, ready2, busy2};

  localparam logic [9:0] RESET_BUS = 10'b0110000010;
  localparam logic [4:0] IDLE_CYC  = 5'b10000;

  int checks = 0;
  int passes = 0;

  // capture results: per CPU cycle {RnW, A14, A13, D0, D7}
  logic [4:0] clog[$];
  int         done_at[$];
  int         rise_clk[$];
  int         nrom_bad, stable_bad, busy_bad, first_clk;
  bit         timeout;

  always #5 CLK = ~CLK;

  mmc1_serial_loader dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(ready1), .req_reset(req_reset),
    .req_reg(req_reg), .req_data(req_data),
    .busy(busy1), .done(done1), .M2(m2_1), .CPU_RnW(rnw1), .nROMSEL(nrom1),
    .CPU_A14(a14_1), .CPU_A13(a13_1), .CPU_D0(d0_1), .CPU_D7(d7_1)
`ifdef MMC1_SHADOW_EN
    , .shadow_ctrl(sh_ctrl), .shadow_chr0(sh_chr0),
    .shadow_chr1(sh_chr1), .shadow_prg(sh_prg)
`endif
  );

  mmc1_serial_loader #(.HALF_CLKS(1), .GAP_CYC(3)) dut2 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid2), .req_ready(ready2), .req_reset(req_reset),
    .req_reg(req_reg), .req_data(req_data),
    .busy(busy2), .done(done2), .M2(m2_2), .CPU_RnW(rnw2), .nROMSEL(nrom2),
    .CPU_A14(a14_2), .CPU_A13(a13_2), .CPU_D0(d0_2), .CPU_D7(d7_2)
`ifdef MMC1_SHADOW_EN
    , .shadow_ctrl(sh2_ctrl), .shadow_chr0(sh2_chr0),
    .shadow_chr1(sh2_chr1), .shadow_prg(sh2_prg)
`endif
  );

  // Record bus activity per CPU cycle starting at the first write cycle,
  // until n_done done pulses are seen or the clock budget runs out.
  task automatic capture(input bit which, input int n_done, input int limit);
    logic [9:0] b;
    logic [4:0] f;
    bit prev_m2, started;
    int clk_i;
    clog.delete(); done_at.delete(); rise_clk.delete();
    nrom_bad = 0; stable_bad = 0; busy_bad = 0; first_clk = -1; timeout = 0;
    started = 0; clk_i = 0;
    b = which ? bus2 : bus1;
    prev_m2 = b[9];
    forever begin
      @(negedge CLK);
      clk_i++;
      b = which ? bus2 : bus1;
      f = {b[8], b[6], b[5], b[4], b[3]};
      if (!prev_m2 && b[9]) rise_clk.push_back(clk_i);
      if (prev_m2 && !b[9]) begin
        if (started || !b[8]) begin
          if (!started) first_clk = clk_i;
          started = 1;
          clog.push_back(f);
        end
      end else if (started && f !== clog[$]) begin
        stable_bad++;
      end
      if (b[7] !== ~(~b[8] & b[9])) nrom_bad++;
      if ((b[1] && !b[8]) || (b[0] !== ~b[1])) busy_bad++;
      if (b[2]) begin
        done_at.push_back(clog.size() - 1);
        if (done_at.size() >= n_done) break;
      end
      if (clk_i >= limit) begin
        timeout = 1;
        break;
      end
      prev_m2 = b[9];
    end
  endtask

  // Present one request, wait (bounded) for acceptance, scramble the
  // request fields while busy, then capture until done.
  task automatic issue(input bit which, input bit rst_f, input logic [1:0] r,
                       input logic [4:0] d, input int limit);
    bit rdy;
    int g;
    @(negedge CLK);
    req_reset = rst_f; req_reg = r; req_data = d;
    if (which) req_valid2 = 1'b1; else req_valid = 1'b1;
    rdy = which ? ready2 : ready1;
    g = 0;
    while (!rdy && g < 100) begin
      @(negedge CLK);
      rdy = which ? ready2 : ready1;
      g++;
    end
    checks++;
    if (rdy !== 1'b1) $display("FAIL issue_ready: req_ready=%b expected 1", rdy);
    else passes++;
    @(posedge CLK);
    #1;
    req_valid = 1'b0; req_valid2 = 1'b0;
    req_reg = ~r; req_data = ~d; req_reset = 1'b0;
    capture(which, 1, limit);
  endtask

  task automatic test_reset();
    int idle_bad, per_bad;
    int rises[$];
    bit prev;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus1 !== RESET_BUS) $display("FAIL reset_values: got %b expected %b", bus1, RESET_BUS);
    else passes++;
    checks++;
    if (bus2 !== RESET_BUS) $display("FAIL reset_values_dut2: got %b expected %b", bus2, RESET_BUS);
    else passes++;
    RST = 1'b0;
    idle_bad = 0; per_bad = 0;
    prev = m2_1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (!prev && m2_1) rises.push_back(i);
      prev = m2_1;
      if (rnw1 !== 1'b1 || nrom1 !== 1'b1 || ready1 !== 1'b1 || done1 !== 1'b0) idle_bad++;
    end
    for (int i = 1; i < rises.size(); i++)
      if (rises[i] - rises[i-1] != 4) per_bad++;
    checks++;
    if (idle_bad != 0) $display("FAIL idle_bus: %0d bad samples expected 0", idle_bad);
    else passes++;
    checks++;
    if (rises.size() < 4 || per_bad != 0)
      $display("FAIL m2_period: rises=%0d bad_periods=%0d expected >=4 rises, period 4", rises.size(), per_bad);
    else passes++;
  endtask

  task automatic test_load();
    logic [4:0] d;
    logic [4:0] exp_w, got;
    int gap_bad;
    d = 5'b10110;
    issue(0, 0, 2'd3, d, 300);
    checks++;
    if (timeout || done_at.size() != 1 || done_at[0] != 10)
      $display("FAIL load_done_cycle: timeout=%0b dones=%0d at=%0d expected 1 done at 10",
               timeout, done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    else passes++;
    checks++;
    if (first_clk - 1 < 1 || first_clk - 1 > 4)
      $display("FAIL load_latency: %0d CLKs expected 1..4", first_clk - 1);
    else passes++;
    gap_bad = 0;
    for (int i = 0; i < 5; i++) begin
      exp_w = {1'b0, 2'b11, d[i], 1'b0};
      got = (2*i < clog.size()) ? clog[2*i] : 5'bxxxxx;
      checks++;
      if (got !== exp_w) $display("FAIL load_write_%0d: got %b expected %b", i, got, exp_w);
      else passes++;
      if (2*i + 1 >= clog.size() || clog[2*i+1] !== IDLE_CYC) gap_bad++;
    end
    checks++;
    if (gap_bad != 0) $display("FAIL load_gaps: %0d non-idle gap cycles expected 0", gap_bad);
    else passes++;
    checks++;
    if (nrom_bad != 0 || stable_bad != 0 || busy_bad != 0)
      $display("FAIL load_protocol: nrom_bad=%0d stable_bad=%0d busy_bad=%0d expected 0/0/0",
               nrom_bad, stable_bad, busy_bad);
    else passes++;
    @(negedge CLK);
    checks++;
    if (done1 !== 1'b0 || ready1 !== 1'b1)
      $display("FAIL done_single_pulse: done=%b ready=%b expected 0 1", done1, ready1);
    else passes++;
`ifdef MMC1_SHADOW_EN
    checks++;
    if (sh_prg !== 5'h16) $display("FAIL shadow_prg: got %h expected 16", sh_prg);
    else passes++;
`endif
  endtask

  task automatic test_reset_request();
    logic [2:0] got;
    issue(0, 0, 2'd0, 5'h01, 300);
    issue(0, 1, 2'd2, 5'h1F, 100);
    got = (clog.size() > 0) ? {clog[0][4], clog[0][1], clog[0][0]} : 3'bxxx;
    checks++;
    if (got !== 3'b001) $display("FAIL rstreq_write: {RnW,D0,D7} got %b expected 001", got);
    else passes++;
    checks++;
    if (clog.size() < 2 || clog[1] !== IDLE_CYC)
      $display("FAIL rstreq_gap: cycles=%0d expected idle gap cycle", clog.size());
    else passes++;
    checks++;
    if (timeout || done_at.size() != 1 || done_at[0] != 2)
      $display("FAIL rstreq_done_cycle: timeout=%0b at=%0d expected 2",
               timeout, (done_at.size() > 0) ? done_at[0] : -1);
    else passes++;
`ifdef MMC1_SHADOW_EN
    checks++;
    if ({sh_ctrl, sh_chr0, sh_chr1, sh_prg} !== {5'h0D, 5'h00, 5'h00, 5'h16})
      $display("FAIL rstreq_shadows: got %h %h %h %h expected 0d 00 00 16",
               sh_ctrl, sh_chr0, sh_chr1, sh_prg);
    else passes++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] regs[3];
    logic [4:0] dats[3];
    logic [4:0] exp_w[$];
    logic [4:0] dv;
    int widx[$];
    int wr_bad, adj_bad, ord_bad, g;
    regs = '{2'd1, 2'd2, 2'd0};
    dats = '{5'h0B, 5'h14, 5'h03};
    for (int i = 0; i < 3; i++) begin
      dv = dats[i];
      for (int j = 0; j < 5; j++) exp_w.push_back({1'b0, regs[i], dv[j], 1'b0});
    end
    @(negedge CLK);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          req_reg = regs[i]; req_data = dats[i]; req_reset = 1'b0; req_valid = 1'b1;
          g = 0;
          while (ready1 !== 1'b1 && g < 200) begin
            @(negedge CLK);
            g++;
          end
          @(negedge CLK);
        end
        req_valid = 1'b0;
      end
      capture(0, 3, 600);
    join
    req_valid = 1'b0;
    for (int i = 0; i < clog.size(); i++) if (clog[i][4] == 1'b0) widx.push_back(i);
    wr_bad = 0; adj_bad = 0; ord_bad = 0;
    for (int i = 0; i < widx.size(); i++)
      if (i >= 15 || clog[widx[i]] !== exp_w[i]) wr_bad++;
    for (int i = 1; i < widx.size(); i++) if (widx[i] == widx[i-1] + 1) adj_bad++;
    checks++;
    if (widx.size() != 15 || wr_bad != 0)
      $display("FAIL b2b_writes: writes=%0d bad=%0d expected 15 writes, 0 bad", widx.size(), wr_bad);
    else passes++;
    checks++;
    if (adj_bad != 0) $display("FAIL b2b_adjacent: %0d adjacent write pairs expected 0", adj_bad);
    else passes++;
    if (done_at.size() == 3 && widx.size() == 15) begin
      for (int i = 0; i < 3; i++) begin
        if (done_at[i] <= widx[5*i+4]) ord_bad++;
        if (i < 2 && done_at[i] >= widx[5*i+5]) ord_bad++;
      end
    end
    checks++;
    if (timeout || done_at.size() != 3 || ord_bad != 0)
      $display("FAIL b2b_done: timeout=%0b dones=%0d order_bad=%0d expected 3 dones in order",
               timeout, done_at.size(), ord_bad);
    else passes++;
    checks++;
    if (busy_bad != 0 || nrom_bad != 0)
      $display("FAIL b2b_ready_busy: busy_bad=%0d nrom_bad=%0d expected 0/0", busy_bad, nrom_bad);
    else passes++;
  endtask

  task automatic test_rst_midload();
    logic [4:0] d;
    logic [4:0] got_bits;
    int falls, g;
    bit prev_rnw;
    @(negedge CLK);
    req_reset = 1'b0; req_reg = 2'd2; req_data = 5'b01101; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    falls = 0; g = 0; prev_rnw = 1'b1;
    while (falls < 2 && g < 200) begin
      @(negedge CLK);
      if (prev_rnw && !rnw1) falls++;
      prev_rnw = rnw1;
      g++;
    end
    checks++;
    if (falls != 2) $display("FAIL midload_second_write: saw %0d writes expected 2", falls);
    else passes++;
    RST = 1'b1;
    #1;
    checks++;
    if (bus1 !== RESET_BUS) $display("FAIL midload_async_reset: got %b expected %b", bus1, RESET_BUS);
    else passes++;
`ifdef MMC1_SHADOW_EN
    checks++;
    if ({sh_ctrl, sh_chr0, sh_chr1, sh_prg} !== 20'h0)
      $display("FAIL midload_shadows: got %h %h %h %h expected 0", sh_ctrl, sh_chr0, sh_chr1, sh_prg);
    else passes++;
`endif
    @(negedge CLK);
    RST = 1'b0;
    d = 5'b10011;
    issue(0, 0, 2'd1, d, 300);
    for (int i = 0; i < 5; i++) got_bits[i] = (2*i < clog.size()) ? clog[2*i][1] : 1'bx;
    checks++;
    if (got_bits !== d || clog.size() < 9 || clog[0][4] !== 1'b0)
      $display("FAIL reload_bits: got %b expected %b", got_bits, d);
    else passes++;
    checks++;
    if (timeout || done_at.size() != 1 || done_at[0] != 10)
      $display("FAIL reload_done_cycle: at=%0d expected 10", (done_at.size() > 0) ? done_at[0] : -1);
    else passes++;
  endtask

  task automatic test_fast_config();
    logic [4:0] d;
    logic [4:0] exp_c;
    int pat_bad, per_bad;
    d = 5'b01011;
    issue(1, 0, 2'd1, d, 300);
    pat_bad = 0;
    for (int i = 0; i < 20; i++) begin
      exp_c = (i % 4 == 0) ? {1'b0, 2'b01, d[i/4], 1'b0} : IDLE_CYC;
      if (i >= clog.size() || clog[i] !== exp_c) pat_bad++;
    end
    checks++;
    if (pat_bad != 0) $display("FAIL fast_pattern: %0d bad cycles expected 0", pat_bad);
    else passes++;
    checks++;
    if (timeout || done_at.size() != 1 || done_at[0] != 20)
      $display("FAIL fast_done_cycle: at=%0d expected 20", (done_at.size() > 0) ? done_at[0] : -1);
    else passes++;
    per_bad = 0;
    for (int i = 1; i < rise_clk.size(); i++) if (rise_clk[i] - rise_clk[i-1] != 2) per_bad++;
    checks++;
    if (rise_clk.size() < 10 || per_bad != 0)
      $display("FAIL fast_m2_period: rises=%0d bad=%0d expected period 2", rise_clk.size(), per_bad);
    else passes++;
    checks++;
    if (first_clk - 1 < 1 || first_clk - 1 > 2 || nrom_bad != 0 || stable_bad != 0)
      $display("FAIL fast_latency_protocol: latency=%0d nrom_bad=%0d stable_bad=%0d expected 1..2/0/0",
               first_clk - 1, nrom_bad, stable_bad);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_reset_request();
    test_back_to_back();
    test_rst_midload();
    test_fast_config();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
